// File: rtl/rx_reset_sequencer.sv
// Turns per-cause watchdog reset requests into a fixed-width active-low pulse for the
// OFDM receiver core. Each pulse is followed by a hold-off window, and the block keeps cause and event statistics.
module rx_reset_sequencer #(
    parameter int unsigned RST_PULSE_LEN = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [3:0]       rst_req,
    input  logic [15:0]      holdoff_cycles,
    input  logic             clear_stats,
    output logic             rx_core_rstn,
    output logic             rst_busy,
    output logic             rst_event,
    output logic [3:0]       last_reason,
    output logic [CNT_W-1:0] rst_count,
    output logic [CNT_W-1:0] suppressed_count
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLDOFF
    } state_t;

    localparam logic [7:0]       PULSE_LAST = 8'(RST_PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t      state;
    logic [7:0]  pulse_cnt;
    logic [15:0] hold_cnt;
    logic        req_d;
    logic        req_any;
    logic        req_rise;
    logic        accept;

    assign req_any  = |rst_req;
    assign req_rise = req_any & ~req_d;
    assign accept   = (state == IDLE) & enable & req_any;

    // NOTE: rx_core_rstn resets to 0 so the core stays held while this block is in reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            rx_core_rstn <= 1'b0;
            rst_busy     <= 1'b0;
            rst_event    <= 1'b0;
            pulse_cnt    <= '0;
            hold_cnt     <= '0;
        end else begin
            rst_event <= accept;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= ASSERT;
                        rx_core_rstn <= 1'b0;
                        rst_busy     <= 1'b1;
                        pulse_cnt    <= PULSE_LAST;
                    end else begin
                        rx_core_rstn <= 1'b1;
                        rst_busy     <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (pulse_cnt == '0) begin
                        rx_core_rstn <= 1'b1;
                        if (holdoff_cycles == '0) begin
                            state    <= IDLE;
                            rst_busy <= 1'b0;
                        end else begin
                            // Window length is latched here; later changes do not stretch it.
                            state    <= HOLDOFF;
                            hold_cnt <= holdoff_cycles;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt - 8'd1;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == 16'd1) begin
                        state    <= IDLE;
                        rst_busy <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    rx_core_rstn <= 1'b1;
                    rst_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Statistics: clear_stats takes priority over any same-cycle capture or increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_d            <= 1'b0;
            last_reason      <= '0;
            rst_count        <= '0;
            suppressed_count <= '0;
        end else begin
            req_d <= req_any;
            if (clear_stats) begin
                last_reason      <= '0;
                rst_count        <= '0;
                suppressed_count <= '0;
            end else begin
                if (accept) begin
                    last_reason <= rst_req;
                    if (rst_count != CNT_MAX) rst_count <= rst_count + 1'b1;
                end
                if ((state != IDLE) && req_rise && (suppressed_count != CNT_MAX))
                    suppressed_count <= suppressed_count + 1'b1;
            end
        end
    end

endmodule
